// File: rtl/nonce_collector_pkg.sv
// -----------------------------------------------------------------------------
// nonce_pkg
// Shared definitions for the nonce collector: word widths, the send-FSM state
// encoding and a saturating adder for the lost-nonce counter.
// No ports (package).
// -----------------------------------------------------------------------------
package nonce_pkg;

  localparam int NONCE_W = 32;
  localparam int DROP_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } send_state_e;

  // Adds up to 16 lost nonces in one cycle, sticking at all-ones.
  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                     input logic [4:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + (DROP_W+1)'(inc);
    if (sum[DROP_W]) begin
      return {DROP_W{1'b1}};
    end else begin
      return sum[DROP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/nonce_collector_fifo.sv
// -----------------------------------------------------------------------------
// nonce_fifo
// Power-of-two synchronous FIFO for golden nonces. The head word is presented
// combinationally on pop_data; push is ignored when full, pop when empty.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write strobe and word
//   pop,  pop_data      read strobe and head word
//   full, empty         status flags
//   level               occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module nonce_fifo
  import nonce_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [NONCE_W-1:0]       push_data,
  input  logic                     pop,
  output logic [NONCE_W-1:0]       pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [NONCE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q,  level_d;
  logic               do_push_s, do_pop_s;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == {(AW+1){1'b0}});
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/nonce_collector.sv
// -----------------------------------------------------------------------------
// nonce_collector
// Gathers golden nonces from CHANNELS hashing cores, queues them in a FIFO via
// a round-robin arbiter and hands them one at a time to a UART transmitter.
// Optional macro NONCE_DEDUP_EN: a nonce identical to the last one pushed is
// dropped silently at arbitration (not queued, no new_nonce, no drop count).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   got_ticket     per-core ticket level (already synchronous to clk)
//   nonces         per-core nonce, channel i at [32i+31:32i]
//   serial_busy    UART busy
//   serial_send    one-cycle send strobe
//   golden_nonce   word being sent; held until the next send
//   new_nonce      one-cycle pulse per queued nonce
//   fifo_level     FIFO occupancy
//   drop_count     saturating count of lost nonces
// -----------------------------------------------------------------------------
module nonce_collector
  import nonce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           got_ticket,
  input  logic [NONCE_W*CHANNELS-1:0]   nonces,
  input  logic                          serial_busy,
  output logic                          serial_send,
  output logic [NONCE_W-1:0]            golden_nonce,
  output logic                          new_nonce,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  // Capture / arbitration state
  logic [CHANNELS-1:0]               ticket_prev_q, ticket_prev_d;
  logic [CHANNELS-1:0]               pending_q, pending_d;
  logic [CHANNELS-1:0][NONCE_W-1:0]  hold_q, hold_d;
  logic [CH_W-1:0]                   rr_q, rr_d;
  logic [DROP_W-1:0]                 drop_q, drop_d;
  logic                              new_nonce_q, new_nonce_d;

  // Send FSM state
  send_state_e                       state_q, state_d;
  logic [TO_W-1:0]                   to_cnt_q, to_cnt_d;
  logic                              serial_send_q, serial_send_d;
  logic [NONCE_W-1:0]                golden_q, golden_d;

  // Arbiter / FIFO glue
  logic                              arb_found_s;
  logic [CH_W-1:0]                   arb_sel_s;
  logic [CH_W-1:0]                   cand_s;
  logic                              arb_go_s;
  logic                              dup_s;
  logic                              push_s;
  logic                              pop_s;
  logic [4:0]                        drop_inc_s;
  logic                              fifo_full_s, fifo_empty_s;
  logic [NONCE_W-1:0]                fifo_head_s;

`ifdef NONCE_DEDUP_EN
  logic [NONCE_W-1:0]                last_q, last_d;
  logic                              last_valid_q, last_valid_d;
`endif

  nonce_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (hold_q[arb_sel_s]),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  // Round-robin search: first pending channel at or after rr.
  always_comb begin
    arb_found_s = 1'b0;
    arb_sel_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand_s = CH_W'((int'(rr_q) + k) % CHANNELS);
      if (!arb_found_s && pending_q[cand_s]) begin
        arb_found_s = 1'b1;
        arb_sel_s   = cand_s;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Capture, drop accounting and FIFO push decision.
  always_comb begin
    ticket_prev_d = got_ticket;
    pending_d     = pending_q;
    hold_d        = hold_q;
    rr_d          = rr_q;
    drop_inc_s    = 5'd0;
    arb_go_s      = arb_found_s & ~fifo_full_s;
`ifdef NONCE_DEDUP_EN
    dup_s         = last_valid_q && (hold_q[arb_sel_s] == last_q);
    last_d        = last_q;
    last_valid_d  = last_valid_q;
`else
    dup_s         = 1'b0;
`endif
    push_s        = arb_go_s & ~dup_s;
    new_nonce_d   = push_s;

    if (arb_go_s) begin
      rr_d = CH_W'((int'(arb_sel_s) + 1) % CHANNELS);
    end else begin
      rr_d = rr_q;
    end

`ifdef NONCE_DEDUP_EN
    if (push_s) begin
      last_d       = hold_q[arb_sel_s];
      last_valid_d = 1'b1;
    end else begin
      last_d       = last_q;
      last_valid_d = last_valid_q;
    end
`endif

    for (int i = 0; i < CHANNELS; i++) begin
      // A channel being drained this cycle may accept a fresh nonce without loss.
      if (got_ticket[i] && !ticket_prev_q[i]) begin
        if (pending_q[i] && !(arb_go_s && (arb_sel_s == CH_W'(i)))) begin
          drop_inc_s = drop_inc_s + 5'd1;
        end else begin
          hold_d[i]    = nonces[i*NONCE_W +: NONCE_W];
          pending_d[i] = 1'b1;
        end
      end else if (arb_go_s && (arb_sel_s == CH_W'(i))) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end

    drop_d = drop_sat_add(drop_q, drop_inc_s);
  end

  // Send FSM next-state and output strobes.
  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    serial_send_d = 1'b0;
    golden_d      = golden_q;
    pop_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s && !serial_busy) begin
          pop_s         = 1'b1;
          serial_send_d = 1'b1;
          golden_d      = fifo_head_s;
          to_cnt_d      = '0;
          state_d       = ST_WAIT_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        // Give up on a UART that never acknowledges so the queue keeps moving.
        if (serial_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_DONE: begin
        if (!serial_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture and arbitration registers. Edge history resets high so a ticket
  // already asserted when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticket_prev_q <= '1;
      pending_q     <= '0;
      hold_q        <= '0;
      rr_q          <= '0;
      drop_q        <= '0;
      new_nonce_q   <= 1'b0;
    end else begin
      ticket_prev_q <= ticket_prev_d;
      pending_q     <= pending_d;
      hold_q        <= hold_d;
      rr_q          <= rr_d;
      drop_q        <= drop_d;
      new_nonce_q   <= new_nonce_d;
    end
  end

  // Send FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      to_cnt_q      <= '0;
      serial_send_q <= 1'b0;
      golden_q      <= '0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      serial_send_q <= serial_send_d;
      golden_q      <= golden_d;
    end
  end

`ifdef NONCE_DEDUP_EN
  // Last-pushed nonce used for duplicate suppression.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  assign serial_send  = serial_send_q;
  assign golden_nonce = golden_q;
  assign new_nonce    = new_nonce_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_nonce_collector.sv
// -----------------------------------------------------------------------------
// tb_nonce_collector
// Directed self-checking bench for nonce_collector (CHANNELS=4, FIFO_DEPTH=8,
// BUSY_TIMEOUT=16). A small UART stand-in raises serial_busy for a few cycles
// after each send when uart_auto is set; otherwise serial_busy follows man_busy.
// -----------------------------------------------------------------------------
module tb_nonce_collector;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    got_ticket = 4'd0;
  logic [127:0]  nonces = 128'd0;
  logic          serial_busy;
  logic          serial_send;
  logic [31:0]   golden_nonce;
  logic          new_nonce;
  logic [3:0]    fifo_level;
  logic [15:0]   drop_count;

  logic          uart_auto = 1'b1;
  logic          man_busy = 1'b0;
  logic [2:0]    auto_cnt = 3'd0;

  logic [31:0]   sent_q[$];
  int            nn_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  nonce_collector #(
    .CHANNELS(4), .FIFO_DEPTH(8), .BUSY_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .got_ticket   (got_ticket),
    .nonces       (nonces),
    .serial_busy  (serial_busy),
    .serial_send  (serial_send),
    .golden_nonce (golden_nonce),
    .new_nonce    (new_nonce),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  assign serial_busy = uart_auto ? (auto_cnt != 3'd0) : man_busy;

  // UART stand-in: busy for four cycles after seeing a send strobe.
  always @(posedge clk) begin
    if (serial_send === 1'b1) auto_cnt <= 3'd4;
    else if (auto_cnt != 3'd0) auto_cnt <= auto_cnt - 3'd1;
  end

  // Record every sent word and every new_nonce pulse.
  always @(negedge clk) begin
    if (serial_send === 1'b1) sent_q.push_back(golden_nonce);
    if (new_nonce === 1'b1) nn_cnt <= nn_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    got_ticket = 4'd0;
    man_busy   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_sends(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (sent_q.size() < target && c < budget) begin
      tick();
      c++;
    end
    check(tag, sent_q.size(), target);
  endtask

  initial begin
    int base;
    int nn_base;
    logic [31:0] exp_w;

    // ---------------- reset state and minimum latency ----------------
    uart_auto = 1'b1;
    do_reset();
    check("rst_send",   {31'd0, serial_send}, 32'd0);
    check("rst_new",    {31'd0, new_nonce},   32'd0);
    check("rst_golden", golden_nonce,         32'd0);
    check("rst_level",  {28'd0, fifo_level},  32'd0);
    check("rst_drop",   {16'd0, drop_count},  32'd0);

    nn_base = nn_cnt;
    nonces[95:64] = 32'h1234ABCD;
    got_ticket    = 4'b0100;
    tick();                                   // edge E: capture
    check("lat_e_new",   {31'd0, new_nonce},   32'd0);
    check("lat_e_level", {28'd0, fifo_level},  32'd0);
    tick();                                   // E+1: push
    check("lat_e1_new",   {31'd0, new_nonce},   32'd1);
    check("lat_e1_level", {28'd0, fifo_level},  32'd1);
    check("lat_e1_send",  {31'd0, serial_send}, 32'd0);
    tick();                                   // E+2: send
    check("lat_e2_send",   {31'd0, serial_send}, 32'd1);
    check("lat_e2_golden", golden_nonce,         32'h1234ABCD);
    check("lat_e2_new",    {31'd0, new_nonce},   32'd0);
    check("lat_e2_level",  {28'd0, fifo_level},  32'd0);
    tick();
    check("lat_e3_send",   {31'd0, serial_send}, 32'd0);
    check("lat_hold",      golden_nonce,         32'h1234ABCD);
    repeat (10) tick();
    check("lat_newcnt", nn_cnt - nn_base, 32'd1);

    // ---------------- four simultaneous rises, round robin ----------------
    do_reset();
    base = sent_q.size();
    for (int i = 0; i < 4; i++) nonces[32*i +: 32] = 32'hA0 + i;
    got_ticket = 4'hF;
    wait_sends(base + 4, 200, "rr_sends");
    for (int i = 0; i < 4; i++) begin
      exp_w = 32'hA0 + i;
      check("rr_order", (sent_q.size() > base + i) ? sent_q[base + i] : 32'hFFFF_FFFF, exp_w);
    end
    check("rr_drop", {16'd0, drop_count}, 32'd0);

    // ---------------- FIFO full with busy stuck high ----------------
    do_reset();
    uart_auto = 1'b0;
    man_busy  = 1'b1;
    base      = sent_q.size();
    nn_base   = nn_cnt;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) nonces[32*i +: 32] = 32'hB0 + 4*r + i;
      got_ticket = 4'hF;
      tick();
      got_ticket = 4'h0;
      repeat (5) tick();
    end
    check("full_level", {28'd0, fifo_level}, 32'd8);
    check("full_drop",  {16'd0, drop_count}, 32'd0);
    check("full_new",   nn_cnt - nn_base,    32'd8);
    check("full_nosend", sent_q.size() - base, 32'd0);
    nonces[31:0] = 32'hDEAD_0000;
    got_ticket   = 4'b0001;                   // channel 0 still pending
    tick();
    got_ticket   = 4'b0000;
    repeat (2) tick();
    check("full_drop1", {16'd0, drop_count}, 32'd1);
    check("full_level2", {28'd0, fifo_level}, 32'd8);
    uart_auto = 1'b1;
    man_busy  = 1'b0;
    wait_sends(base + 12, 600, "full_drain");
    for (int i = 0; i < 12; i++) begin
      exp_w = 32'hB0 + i;
      check("full_order", (sent_q.size() > base + i) ? sent_q[base + i] : 32'hFFFF_FFFF, exp_w);
    end

    // ---------------- busy never rises: timeout ----------------
    do_reset();
    uart_auto = 1'b0;
    man_busy  = 1'b0;
    nonces[31:0]  = 32'hC0;
    nonces[63:32] = 32'hC1;
    got_ticket    = 4'b0011;
    begin
      int c;
      c = 0;
      while (serial_send !== 1'b1 && c < 20) begin
        tick();
        c++;
      end
    end
    check("to_first", golden_nonce, 32'hC0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("to_send", {31'd0, serial_send}, (k == 17) ? 32'd1 : 32'd0);
    end
    check("to_second", golden_nonce, 32'hC1);

    // ---------------- duplicate nonce on two channels ----------------
    do_reset();
    uart_auto = 1'b1;
    base      = sent_q.size();
    nn_base   = nn_cnt;
    nonces[31:0]  = 32'h55AA55AA;
    nonces[63:32] = 32'h55AA55AA;
    got_ticket    = 4'b0011;
    repeat (60) tick();
`ifdef NONCE_DEDUP_EN
    check("dup_sends", sent_q.size() - base, 32'd1);
    check("dup_new",   nn_cnt - nn_base,     32'd1);
`else
    check("dup_sends", sent_q.size() - base, 32'd2);
    check("dup_new",   nn_cnt - nn_base,     32'd2);
`endif
    check("dup_drop", {16'd0, drop_count}, 32'd0);

    // ---------------- reset during WAIT_DONE ----------------
    do_reset();
    uart_auto = 1'b0;
    man_busy  = 1'b0;
    for (int i = 0; i < 4; i++) nonces[32*i +: 32] = 32'hD0 + i;
    got_ticket = 4'hF;
    tick();                                   // capture
    tick();                                   // push ch0
    tick();                                   // send D0
    check("rw_send", {31'd0, serial_send}, 32'd1);
    man_busy = 1'b1;
    repeat (3) tick();
    check("rw_level", {28'd0, fifo_level}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rw_r_send",   {31'd0, serial_send}, 32'd0);
    check("rw_r_new",    {31'd0, new_nonce},   32'd0);
    check("rw_r_golden", golden_nonce,         32'd0);
    check("rw_r_level",  {28'd0, fifo_level},  32'd0);
    check("rw_r_drop",   {16'd0, drop_count},  32'd0);
    repeat (2) tick();
    man_busy = 1'b0;
    rst_n    = 1'b1;                          // tickets still high
    base     = sent_q.size();
    nn_base  = nn_cnt;
    repeat (20) tick();
    check("rw_nosend", sent_q.size() - base, 32'd0);
    check("rw_nonew",  nn_cnt - nn_base,     32'd0);
    check("rw_level2", {28'd0, fifo_level},  32'd0);
    got_ticket = 4'h0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
